// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/wb).
// Ports: clk, reset (async, active-high), opcode[5:0], zero -> datapath selects,
//   write enables, ALUOp[1:0], PCEn, illegal_op, state_dbg[3:0].
//   Optional macro MC_JUMP_EN adds the J (000010) instruction.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
`ifdef MC_JUMP_EN
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
`else
    S_ADDIWB   = 4'd10
`endif
  } state_t;

  state_t r_state;
  state_t w_dec_next;
  logic   w_legal;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;
  logic   w_pcwrite;
  logic   w_branch;

  always_comb begin
    w_legal    = 1'b1;
    w_dec_next = S_FETCH;
    case (opcode)
      OP_LW, OP_SW: w_dec_next = S_MEMADR;
      OP_R:         w_dec_next = S_EXECUTE;
      OP_BEQ:       w_dec_next = S_BRANCH;
      OP_ADDI:      w_dec_next = S_ADDIEXEC;
`ifdef MC_JUMP_EN
      OP_J:         w_dec_next = S_JUMP;
`endif
      default:      w_legal    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        // IR is stable, so opcode picks load vs store here
        S_MEMADR: begin
          if (opcode == OP_LW)      r_state <= S_MEMRD;
          else if (opcode == OP_SW) r_state <= S_MEMWR;
          else                      r_state <= S_FETCH;
        end
        S_MEMRD:    r_state <= S_MEMWB;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    IorD       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    w_regwrite = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        ALUSrcB   = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
`ifdef MC_JUMP_EN
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // enables are masked while reset is held so an aborted instruction writes nothing
  assign MemWrite   = w_memwrite & ~reset;
  assign IRWrite    = w_irwrite & ~reset;
  assign RegWrite   = w_regwrite & ~reset;
  assign PCEn       = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign illegal_op = (r_state == S_DECODE) & ~w_legal & ~reset;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control.
// Reference model expands each opcode into its expected per-cycle control words.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, illegal_op;
  logic [3:0] state_dbg;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {state_dbg, IorD, MemWrite, IRWrite, RegDst,
                     MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSrc, PCEn, illegal_op};

  int n_chk = 0;
  int n_pass = 0;
  logic [18:0] exp_q[$];

  // wr bits: IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA
  function automatic logic [18:0] mk(input logic [3:0] st,
    input logic [6:0] wr, input logic [1:0] asb, input logic [1:0] aop,
    input logic [1:0] pcs, input logic pcen, input logic ill);
    return {st, wr, asb, aop, pcs, pcen, ill};
  endfunction

  function automatic bit jump_en();
`ifdef MC_JUMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  wire [18:0] rst_word = mk(4'd0, 7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);

  task automatic build(input logic [5:0] op, input logic z);
    logic [18:0] dec_ok;
    dec_ok = mk(4'd1, 7'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back(mk(4'd0, 7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0));
    if (op == 6'b100011) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd2, 7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd3, 7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd4, 7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    end else if (op == 6'b101011) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd2, 7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd5, 7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    end else if (op == 6'b000000) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd6, 7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd7, 7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    end else if (op == 6'b000100) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd8, 7'b0000001, 2'b00, 2'b01, 2'b01, z, 1'b0));
    end else if (op == 6'b001000) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd9, 7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(mk(4'd10, 7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
    end else if (op == 6'b000010 && jump_en()) begin
      exp_q.push_back(dec_ok);
      exp_q.push_back(mk(4'd11, 7'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(mk(4'd1, 7'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; opcode = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1; n_chk++;
    if (obs !== rst_word) $display("FAIL reset_hold got %h exp %h", obs, rst_word);
    else n_pass++;
    @(negedge clk);
    #1; n_chk++;
    if (obs !== rst_word) $display("FAIL reset_hold2 got %h exp %h", obs, rst_word);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    int n_aluop10;
    n_aluop10 = 0;
    opcode = 6'b000000; zero = 1'($urandom);
    build(opcode, zero);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1; n_chk++;
      if (obs !== exp_q[i]) $display("FAIL rtype step %0d got %h exp %h", i, obs, exp_q[i]);
      else n_pass++;
      if (ALUOp == 2'b10) n_aluop10++;
      @(negedge clk);
    end
    n_chk++;
    if (n_aluop10 !== 1) $display("FAIL rtype_aluop10_cycles got %0d exp 1", n_aluop10);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n_mw;
    logic [5:0] ops[2];
    n_mw = 0;
    ops[0] = 6'b100011; ops[1] = 6'b101011;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; zero = 1'($urandom);
      build(opcode, zero);
      for (int i = 0; i < exp_q.size(); i++) begin
        #1; n_chk++;
        if (obs !== exp_q[i]) $display("FAIL lw_sw op%0d step %0d got %h exp %h", k, i, obs, exp_q[i]);
        else n_pass++;
        if (MemWrite) n_mw++;
        @(negedge clk);
      end
    end
    n_chk++;
    if (n_mw !== 1) $display("FAIL sw_memwrite_cycles got %0d exp 1", n_mw);
    else n_pass++;
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; zero = 1'(z);
      build(opcode, zero);
      for (int i = 0; i < exp_q.size(); i++) begin
        #1; n_chk++;
        if (obs !== exp_q[i]) $display("FAIL beq z%0d step %0d got %h exp %h", z, i, obs, exp_q[i]);
        else n_pass++;
        if (i == 2) begin
          zero = ~zero;
          #1; n_chk++;
          if (PCEn !== zero) $display("FAIL beq_zero_toggle got %b exp %b", PCEn, zero);
          else n_pass++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_addi;
    opcode = 6'b001000; zero = 1'($urandom);
    build(opcode, zero);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1; n_chk++;
      if (obs !== exp_q[i]) $display("FAIL addi step %0d got %h exp %h", i, obs, exp_q[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_and_jump;
    logic [5:0] ops[2];
    ops[0] = 6'b111111; ops[1] = 6'b000010;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; zero = 1'b0;
      build(opcode, zero);
      for (int i = 0; i < exp_q.size(); i++) begin
        #1; n_chk++;
        if (obs !== exp_q[i]) $display("FAIL illegal_jump op %b step %0d got %h exp %h", opcode, i, obs, exp_q[i]);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] tbl[6];
    int sel, nwe;
    tbl[0] = 6'b000000; tbl[1] = 6'b100011; tbl[2] = 6'b101011;
    tbl[3] = 6'b000100; tbl[4] = 6'b001000; tbl[5] = 6'b000010;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 6));
      opcode = (sel == 6) ? 6'($urandom) : tbl[sel];
      zero = 1'($urandom);
      build(opcode, zero);
      for (int i = 0; i < exp_q.size(); i++) begin
        #1; n_chk++;
        if (obs !== exp_q[i]) $display("FAIL random op %b step %0d got %h exp %h", opcode, i, obs, exp_q[i]);
        else n_pass++;
        nwe = int'(MemWrite) + int'(RegWrite) + int'(IRWrite);
        n_chk++;
        if (nwe > 1) $display("FAIL write_exclusive got %0d exp <=1", nwe);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_lw;
    opcode = 6'b100011; zero = 1'b0;
    build(opcode, zero);
    for (int i = 0; i < 4; i++) begin
      #1; n_chk++;
      if (obs !== exp_q[i]) $display("FAIL midlw step %0d got %h exp %h", i, obs, exp_q[i]);
      else n_pass++;
      if (i < 3) @(negedge clk);
    end
    reset = 1'b1;
    #1; n_chk++;
    if (obs !== rst_word) $display("FAIL midlw_async got %h exp %h", obs, rst_word);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      #1; n_chk++;
      if (obs !== rst_word) $display("FAIL midlw_held got %h exp %h", obs, rst_word);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1; n_chk++;
      if (obs !== exp_q[i]) $display("FAIL midlw_restart step %0d got %h exp %h", i, obs, exp_q[i]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_back_to_back;
    test_beq;
    test_addi;
    test_illegal_and_jump;
    test_random;
    test_reset_mid_lw;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
